// File: rtl/game_flow_pkg.sv
// game_flow_pkg
//   Shared types for the Road Fighter game flow: the game phase enum used by
//   game_flow_controller and the screen-select codes consumed by the objects
//   mux. Also provides a small helper for sizing frame counters.
package game_flow_pkg;

  typedef enum logic [2:0] {
    INTRO     = 3'd0,
    COUNTDOWN = 3'd1,
    RUNNING   = 3'd2,
    PAUSED    = 3'd3,
    CRASH     = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    SCR_INTRO    = 2'd0,
    SCR_GAME     = 2'd1,
    SCR_GAMEOVER = 2'd2
  } screen_sel_t;

  // Largest of three frame-count parameters; sizes the shared frame counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect
//   Turns a key level into a one-cycle rise pulse.
//   Ports: clk, reset (sync, active-high), key (level in), rise (pulse out).
//   The previous-level register resets to 1 so a key that is already held
//   when reset releases is not reported as a fresh press.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic key_prev;

  always_ff @(posedge clk) begin
    if (reset) key_prev <= 1'b1;
    else       key_prev <= key;
  end

  assign rise = key & ~key_prev;

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller
//   Central game-state sequencer: intro, countdown, running, paused, crash
//   and game-over phases; lives counting; screen select and motion freeze.
//   All phase timing is in video frames (startOfFrame pulses).
//   Ports:
//     clk, reset          system clock, synchronous active-high reset
//     startOfFrame        one-cycle pulse per video frame
//     enterKey, pauseKey  key levels (edges detected internally)
//     collision           player/obstacle overlap, any pixel cycle
//     fuelEmpty           fuel exhausted level
//     screenSel           screen to display (intro / game / game over)
//     game_running        high in COUNTDOWN, RUNNING, PAUSED, CRASH
//     freeze              high in every phase except RUNNING
//     livesLeft           remaining lives
//     countdownDigit      3/2/1 during COUNTDOWN, else 0
//     newGameStrobe       one-cycle pulse on the first COUNTDOWN cycle
//     dbg_state           current phase, for observation only
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int CRASH_FRAMES     = 90,
  parameter int GAMEOVER_FRAMES  = 120,
  parameter int LIVES            = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enterKey,
  input  logic        pauseKey,
  input  logic        collision,
  input  logic        fuelEmpty,
  output screen_sel_t screenSel,
  output logic        game_running,
  output logic        freeze,
  output logic [1:0]  livesLeft,
  output logic [1:0]  countdownDigit,
  output logic        newGameStrobe,
  output game_state_t dbg_state
);

  localparam int CNT_W = $clog2(max3(FRAMES_PER_DIGIT, CRASH_FRAMES, GAMEOVER_FRAMES)) + 1;

  localparam logic [CNT_W-1:0] DIGIT_LOAD    = CNT_W'(FRAMES_PER_DIGIT);
  localparam logic [CNT_W-1:0] CRASH_LOAD    = CNT_W'(CRASH_FRAMES);
  localparam logic [CNT_W-1:0] GAMEOVER_LOAD = CNT_W'(GAMEOVER_FRAMES);
  localparam logic [1:0]       LIVES_INIT    = 2'(LIVES);

  logic enter_rise, pause_rise;

  key_edge_detect u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .key   (enterKey),
    .rise  (enter_rise)
  );

  key_edge_detect u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .key   (pauseKey),
    .rise  (pause_rise)
  );

  game_state_t      state, state_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n, cnt_dec;
  logic [1:0]       digit, digit_n;
  logic [1:0]       lives, lives_n;
  logic             crash_flag, crash_flag_n;
  logic             strobe_n;
  logic             crash_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INTRO;
      frame_cnt     <= '0;
      digit         <= 2'd0;
      lives         <= LIVES_INIT;
      crash_flag    <= 1'b0;
      newGameStrobe <= 1'b0;
    end else begin
      state         <= state_n;
      frame_cnt     <= frame_cnt_n;
      digit         <= digit_n;
      lives         <= lives_n;
      crash_flag    <= crash_flag_n;
      newGameStrobe <= strobe_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    digit_n     = digit;
    lives_n     = lives;
    strobe_n    = 1'b0;
    // Saturating decrement: frame counter never wraps.
    cnt_dec     = (frame_cnt == '0) ? '0 : frame_cnt - CNT_W'(1);
    // A collision on the frame-boundary cycle itself still counts, since the
    // sticky flag is cleared on that same cycle.
    crash_hit   = crash_flag | collision;
    // Collisions only accumulate between frame boundaries while RUNNING.
    crash_flag_n = (state == RUNNING && !startOfFrame) ? (crash_flag | collision) : 1'b0;

    unique case (state)
      INTRO: begin
        if (enter_rise) begin
          state_n     = COUNTDOWN;
          lives_n     = LIVES_INIT;
          digit_n     = 2'd3;
          frame_cnt_n = DIGIT_LOAD;
          strobe_n    = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (startOfFrame) begin
          frame_cnt_n = cnt_dec;
          if (cnt_dec == '0) begin
            if (digit > 2'd1) begin
              digit_n     = digit - 2'd1;
              frame_cnt_n = DIGIT_LOAD;
            end else begin
              state_n = RUNNING;
            end
          end
        end
      end
      RUNNING: begin
        // Frame-boundary transitions take priority over a simultaneous pause.
        if (startOfFrame && fuelEmpty) begin
          state_n     = GAME_OVER;
          frame_cnt_n = GAMEOVER_LOAD;
        end else if (startOfFrame && crash_hit) begin
          state_n     = CRASH;
          lives_n     = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          frame_cnt_n = CRASH_LOAD;
        end else if (pause_rise) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_rise) state_n = RUNNING;
      end
      CRASH: begin
        if (startOfFrame) begin
          frame_cnt_n = cnt_dec;
          if (cnt_dec == '0) begin
            if (lives == 2'd0) begin
              state_n     = GAME_OVER;
              frame_cnt_n = GAMEOVER_LOAD;
            end else begin
              state_n = RUNNING;
            end
          end
        end
      end
      GAME_OVER: begin
        if (enter_rise && frame_cnt == '0) begin
          state_n     = INTRO;
          frame_cnt_n = '0;
        end else if (startOfFrame) begin
          frame_cnt_n = cnt_dec;
        end
      end
      default: state_n = INTRO;
    endcase
  end

  // Moore outputs decoded from the registered phase.
  always_comb begin
    screenSel = SCR_GAME;
    if (state == INTRO)     screenSel = SCR_INTRO;
    if (state == GAME_OVER) screenSel = SCR_GAMEOVER;
  end

  assign game_running   = (state == COUNTDOWN) || (state == RUNNING) ||
                          (state == PAUSED)    || (state == CRASH);
  assign freeze         = (state != RUNNING);
  assign livesLeft      = lives;
  assign countdownDigit = (state == COUNTDOWN) ? digit : 2'd0;
  assign dbg_state      = state;

endmodule
